// File: rtl/ex_stage.sv
// ex_stage: execute stage with an iterative RV32M multiply/divide sequencer and the EX/MEM register.
// Latency: 1 cycle for ALU ops; M ops hold stall_out 33 cycles and retire on the 34th cycle.
// Backpressure: stall_in freezes the EX/MEM register (and DONE); stall_out holds upstream during M ops.

package ex_stage_pkg;

    typedef struct packed {
        logic [31:0] opr_res;
        logic [31:0] opr_b;
        logic        dm_en;
        logic [2:0]  lsuop;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        rf_en;
        logic [1:0]  wb_sel;
    } mem_stage_in_t;

endpackage

module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] alu_res,
    input  logic [DATA_WIDTH-1:0] opr_a,
    input  logic [DATA_WIDTH-1:0] opr_b,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  md_en,
    input  logic [2:0]            mdop,
    input  logic                  dm_en,
    input  logic [2:0]            lsuop,
    input  logic [4:0]            rd,
    input  logic [DATA_WIDTH-1:0] pc4,
    input  logic                  rf_en,
    input  logic [1:0]            wb_sel,
    input  logic                  stall_in,
    input  logic                  flush_in,
    output mem_stage_in_t         ex_stage_out,
    output logic                  valid_out,
    output logic                  stall_out
);

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [2:0]    mdop_q, mdop_d;
    // Multiply: {partial product high, multiplier shifting out}. Divide: {remainder, dividend/quotient}.
    logic [63:0]   acc_q, acc_d;
    // Multiplicand magnitude or divisor magnitude.
    logic [31:0]   opd_q, opd_d;
    logic          neg_q, neg_d;
    logic          a_sgn_q, a_sgn_d;
    logic          divz_q, divz_d;
    mem_stage_in_t out_q, out_d;
    logic          vld_q, vld_d;

    logic          md_req;
    logic          a_signed, b_signed, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag;
    logic [32:0]   mul_sum;
    logic          div_ge;
    logic [31:0]   div_diff;
    logic [63:0]   prod;
    logic [31:0]   quo, rem, m_res;

    assign md_req = valid_in & md_en;

    // Operand sign decode and magnitude extraction for a newly arriving M op
    always_comb begin
        a_signed = (mdop == MD_MULH) | (mdop == MD_MULHSU) | (mdop == MD_DIV) | (mdop == MD_REM);
        b_signed = (mdop == MD_MULH) | (mdop == MD_DIV) | (mdop == MD_REM);
        a_neg    = a_signed & opr_a[31];
        b_neg    = b_signed & opr_b[31];
        a_mag    = a_neg ? (32'd0 - opr_a) : opr_a;
        b_mag    = b_neg ? (32'd0 - opr_b) : opr_b;
    end

    // One radix-2 step: shift-add for multiply, trial subtract for restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opd_q};
        // Shifted remainder is acc_q[63:31]; a set MSB means it exceeds any 32-bit divisor.
        div_ge   = acc_q[63] | (acc_q[62:31] >= opd_q);
        div_diff = acc_q[62:31] - opd_q;
    end

    // Sign fix-up and result selection from the finished accumulator
    always_comb begin
        prod = neg_q ? (64'd0 - acc_q) : acc_q;
        // Divide by zero yields all ones regardless of sign; the remainder path already holds the dividend.
        quo  = divz_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
        rem  = a_sgn_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        case (mdop_q)
            MD_MUL:                       m_res = prod[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: m_res = prod[63:32];
            MD_DIV, MD_DIVU:              m_res = quo;
            default:                      m_res = rem;
        endcase
    end

    // Sequencer next state: start on a new M op, step while busy, hold DONE until retired
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mdop_d  = mdop_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        neg_d   = neg_q;
        a_sgn_d = a_sgn_q;
        divz_d  = divz_q;
        case (state_q)
            IDLE: begin
                if (md_req & ~flush_in) begin
                    state_d = BUSY;
                    cnt_d   = 5'd0;
                    mdop_d  = mdop;
                    neg_d   = a_neg ^ b_neg;
                    a_sgn_d = a_neg;
                    divz_d  = (opr_b == 32'd0);
                    if (mdop[2]) begin
                        acc_d = {32'd0, a_mag};
                        opd_d = b_mag;
                    end else begin
                        acc_d = {32'd0, b_mag};
                        opd_d = a_mag;
                    end
                end
            end
            BUSY: begin
                if (flush_in) begin
                    state_d = IDLE;
                end else begin
                    if (mdop_q[2]) begin
                        acc_d = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
                    end else begin
                        acc_d = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (flush_in | ~stall_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // EX/MEM register: flush beats hold, hold beats capture; M ops only retire from DONE
    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        if (flush_in) begin
            vld_d = 1'b0;
        end else if (!stall_in) begin
            vld_d          = valid_in & ~(md_en & (state_q != DONE));
            out_d.opr_res  = (md_en & (state_q == DONE)) ? m_res : alu_res;
            out_d.opr_b    = store_data;
            out_d.dm_en    = dm_en;
            out_d.lsuop    = lsuop;
            out_d.rd       = rd;
            out_d.pc4      = pc4;
            out_d.rf_en    = rf_en;
            out_d.wb_sel   = wb_sel;
        end
    end

    // State and pipeline flops; reset drops any in-flight M op
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            mdop_q  <= 3'd0;
            acc_q   <= 64'd0;
            opd_q   <= 32'd0;
            neg_q   <= 1'b0;
            a_sgn_q <= 1'b0;
            divz_q  <= 1'b0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mdop_q  <= mdop_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            neg_q   <= neg_d;
            a_sgn_q <= a_sgn_d;
            divz_q  <= divz_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign ex_stage_out = out_q;
    assign valid_out    = vld_q;
    assign stall_out    = stall_in | (md_req & (state_q != DONE));

endmodule
